// File: rtl/crc_frame_checker.sv
// crc_frame_checker: multi-block CRC check of fixed-length receive frames.
// Optional per-block mismatch counters: define CRC_CHK_BLK_CNT_EN.
module crc_frame_checker #(
    parameter int                    DATA_W  = 62,
    parameter int                    BEATS   = 26,
    parameter int                    NUM_BLK = 4,
    parameter logic [16*NUM_BLK-1:0] BLK_LEN = {16'd400, 16'd375, 16'd403, 16'd390},
    parameter int                    CRC_W   = 10,
    parameter logic [CRC_W-1:0]      POLY    = 10'h233,
    parameter int                    CNT_W   = 23
) (
    input  logic                     clk_390p625M,
    input  logic                     rst_n,
    input  logic                     crc_en,
    input  logic [DATA_W-1:0]        crc_data_in,
    input  logic                     frame_tail_flag,
    input  logic                     cnt_clr,
    output logic                     check_valid,
    output logic                     check_result,
    output logic [NUM_BLK-1:0]       blk_err,
    output logic                     frame_err,
`ifdef CRC_CHK_BLK_CNT_EN
    output logic [NUM_BLK*CNT_W-1:0] blk_err_cnt,
`endif
    output logic [CNT_W-1:0]         error_packet_cnt
);

    function automatic int blk_start(input int k);
        int s;
        s = 0;
        for (int j = 0; j < k; j++) s += int'(BLK_LEN[16*j +: 16]);
        return s;
    endfunction

    localparam int L_TOT    = blk_start(NUM_BLK);
    localparam int END_BITS = L_TOT + NUM_BLK * CRC_W;
    localparam int BW       = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if (END_BITS > BEATS * DATA_W) begin : g_len_err
            $error("crc_frame_checker: frame too short for blocks and CRC fields");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t                          state_q, state_d;
    logic [BW-1:0]                   beat_q, beat_d;
    logic [NUM_BLK-1:0][CRC_W-1:0]   lfsr_q, lfsr_d, lfsr_nx;
    logic [NUM_BLK-1:0][CRC_W-1:0]   rx_q, rx_d, rx_nx;
    logic [NUM_BLK-1:0]              mm;
    logic                            last, frame_end, end_ok, fail;
    logic                            valid_q, valid_d;
    logic                            result_q, result_d;
    logic [NUM_BLK-1:0]              blk_err_q, blk_err_d;
    logic                            frame_err_q, frame_err_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;

    // Each stream bit is routed to the LFSR or received-CRC register it belongs to.
    always_comb begin
        int   b;
        logic fbk;
        b       = 0;
        fbk     = 1'b0;
        lfsr_nx = lfsr_q;
        rx_nx   = rx_q;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            b = int'(beat_q) * DATA_W + (DATA_W - 1 - i);
            for (int k = 0; k < NUM_BLK; k++) begin
                if (b >= blk_start(k) && b < blk_start(k + 1)) begin
                    fbk        = lfsr_nx[k][CRC_W-1] ^ crc_data_in[i];
                    lfsr_nx[k] = {lfsr_nx[k][CRC_W-2:0], 1'b0} ^ (fbk ? POLY : '0);
                end
                if (b >= L_TOT + k * CRC_W && b < L_TOT + (k + 1) * CRC_W) begin
                    rx_nx[k] = {rx_nx[k][CRC_W-2:0], crc_data_in[i]};
                end
            end
        end
        for (int k = 0; k < NUM_BLK; k++) mm[k] = (lfsr_nx[k] != rx_nx[k]);
    end

    assign last      = (int'(beat_q) == BEATS - 1);
    assign frame_end = crc_en && (frame_tail_flag || last);
    assign end_ok    = crc_en && frame_tail_flag && last;
    assign fail      = frame_end && !(end_ok && (mm == '0));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        lfsr_d  = lfsr_q;
        rx_d    = rx_q;
        case (state_q)
            IDLE:    if (crc_en && !frame_end) state_d = RUN;
            RUN:     if (frame_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (crc_en) begin
            if (frame_end) begin
                beat_d = '0;
                lfsr_d = '0;
                rx_d   = '0;
            end else begin
                beat_d = beat_q + 1'b1;
                lfsr_d = lfsr_nx;
                rx_d   = rx_nx;
            end
        end
    end

    always_comb begin
        valid_d     = frame_end;
        result_d    = result_q;
        blk_err_d   = blk_err_q;
        frame_err_d = frame_err_q;
        if (frame_end) begin
            result_d    = end_ok && (mm == '0);
            blk_err_d   = end_ok ? mm : '1;
            frame_err_d = !end_ok;
        end
        cnt_d = cnt_q;
        if (cnt_clr) cnt_d = '0;
        else if (fail && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            lfsr_q      <= '0;
            rx_q        <= '0;
            valid_q     <= 1'b0;
            result_q    <= 1'b0;
            blk_err_q   <= '0;
            frame_err_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            lfsr_q      <= lfsr_d;
            rx_q        <= rx_d;
            valid_q     <= valid_d;
            result_q    <= result_d;
            blk_err_q   <= blk_err_d;
            frame_err_q <= frame_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign check_valid      = valid_q;
    assign check_result     = result_q;
    assign blk_err          = blk_err_q;
    assign frame_err        = frame_err_q;
    assign error_packet_cnt = cnt_q;

`ifdef CRC_CHK_BLK_CNT_EN
    logic [NUM_BLK-1:0][CNT_W-1:0] bcnt_q, bcnt_d;

    // Only complete frames are attributed to individual blocks.
    always_comb begin
        bcnt_d = bcnt_q;
        for (int k = 0; k < NUM_BLK; k++) begin
            if (cnt_clr) bcnt_d[k] = '0;
            else if (end_ok && mm[k] && !(&bcnt_q[k])) bcnt_d[k] = bcnt_q[k] + 1'b1;
        end
    end

    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) bcnt_q <= '0;
        else        bcnt_q <= bcnt_d;
    end

    assign blk_err_cnt = bcnt_q;
`endif

endmodule

// File: tb/tb_crc_frame_checker.sv
// tb_crc_frame_checker: table vectors, corner sequences and random frames
// checked against a polynomial long-division reference model.
`timescale 1ns/1ps
module tb_crc_frame_checker;

    localparam int          DATA_W  = 62;
    localparam int          BEATS   = 26;
    localparam int          NUM_BLK = 4;
    localparam logic [63:0] BLK_LEN = {16'd400, 16'd375, 16'd403, 16'd390};
    localparam int          CRC_W   = 10;
    localparam logic [9:0]  POLY    = 10'h233;
    localparam int          CNT_W   = 23;
    localparam int          FB      = BEATS * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              crc_en;
    logic [DATA_W-1:0] crc_data_in;
    logic              frame_tail_flag;
    logic              cnt_clr;

    logic              check_valid, check_result, frame_err;
    logic [3:0]        blk_err;
    logic [CNT_W-1:0]  error_packet_cnt;
    logic              cv3, cr3, fe3;
    logic [3:0]        be3;
    logic [2:0]        cnt3;
`ifdef CRC_CHK_BLK_CNT_EN
    logic [NUM_BLK*CNT_W-1:0] bcnt;
    logic [NUM_BLK*3-1:0]     bcnt3;
`endif

    crc_frame_checker #(
        .DATA_W(DATA_W), .BEATS(BEATS), .NUM_BLK(NUM_BLK), .BLK_LEN(BLK_LEN),
        .CRC_W(CRC_W), .POLY(POLY), .CNT_W(CNT_W)
    ) u_dut (
        .clk_390p625M(clk), .rst_n(rst_n), .crc_en(crc_en),
        .crc_data_in(crc_data_in), .frame_tail_flag(frame_tail_flag),
        .cnt_clr(cnt_clr), .check_valid(check_valid),
        .check_result(check_result), .blk_err(blk_err), .frame_err(frame_err),
`ifdef CRC_CHK_BLK_CNT_EN
        .blk_err_cnt(bcnt),
`endif
        .error_packet_cnt(error_packet_cnt)
    );

    crc_frame_checker #(
        .DATA_W(DATA_W), .BEATS(BEATS), .NUM_BLK(NUM_BLK), .BLK_LEN(BLK_LEN),
        .CRC_W(CRC_W), .POLY(POLY), .CNT_W(3)
    ) u_dut3 (
        .clk_390p625M(clk), .rst_n(rst_n), .crc_en(crc_en),
        .crc_data_in(crc_data_in), .frame_tail_flag(frame_tail_flag),
        .cnt_clr(cnt_clr), .check_valid(cv3),
        .check_result(cr3), .blk_err(be3), .frame_err(fe3),
`ifdef CRC_CHK_BLK_CNT_EN
        .blk_err_cnt(bcnt3),
`endif
        .error_packet_cnt(cnt3)
    );

    always #1.28 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int blen[NUM_BLK];
    int bst[NUM_BLK];
    int ltot;
    bit fb[FB];
    int n_pass = 0;
    int n_tot  = 0;
    int m23, m3;
    int mb[NUM_BLK];

    typedef struct {
        string      nm;
        int         flip;
        int         tail;
        int         nb;
        int         sa;
        int         sb;
        bit         clr;
        bit         res;
        logic [3:0] blk;
        bit         ferr;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        else n_pass++;
    endtask

    // Remainder of block*x^CRC_W divided by the full generator polynomial.
    function automatic logic [CRC_W-1:0] div_crc(input int k);
        bit               arr[FB + CRC_W];
        logic [CRC_W:0]   g;
        logic [CRC_W-1:0] r;
        g = {1'b1, POLY};
        for (int p = 0; p < FB + CRC_W; p++) arr[p] = 1'b0;
        for (int p = 0; p < blen[k]; p++) arr[p] = fb[bst[k] + p];
        for (int p = 0; p < blen[k]; p++)
            if (arr[p])
                for (int m = 0; m <= CRC_W; m++) arr[p + m] ^= g[CRC_W - m];
        for (int m = 0; m < CRC_W; m++) r[CRC_W - 1 - m] = arr[blen[k] + m];
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] field(input int k);
        logic [CRC_W-1:0] r;
        for (int m = 0; m < CRC_W; m++) r[CRC_W - 1 - m] = fb[ltot + k * CRC_W + m];
        return r;
    endfunction

    task automatic put_crcs();
        logic [CRC_W-1:0] c;
        for (int k = 0; k < NUM_BLK; k++) begin
            c = div_crc(k);
            for (int m = 0; m < CRC_W; m++) fb[ltot + k * CRC_W + m] = c[CRC_W - 1 - m];
        end
    endtask

    function automatic logic [3:0] model_blk();
        logic [3:0] e;
        for (int k = 0; k < NUM_BLK; k++) e[k] = (div_crc(k) != field(k));
        return e;
    endfunction

    task automatic build_test(input int flip);
        logic [415:0] v[NUM_BLK];
        v[0] = 416'({26{15'h4965}});
        v[1] = 416'({{25{16'h8B61}}, 3'b010});
        v[2] = 416'({25{15'h3F3E}});
        v[3] = 416'({25{16'h8B61}});
        for (int b = 0; b < FB; b++) fb[b] = 1'b0;
        for (int k = 0; k < NUM_BLK; k++)
            for (int j = 0; j < blen[k]; j++) fb[bst[k] + j] = v[k][blen[k] - 1 - j];
        put_crcs();
        if (flip >= 0) fb[bst[flip]] = ~fb[bst[flip]];
    endtask

    function automatic logic [127:0] exp_bcnt(input int w);
        logic [127:0] e;
        int           v;
        e = '0;
        for (int k = 0; k < NUM_BLK; k++) begin
            v = (mb[k] > (1 << w) - 1) ? (1 << w) - 1 : mb[k];
            e = e | (128'(v) << (k * w));
        end
        return e;
    endfunction

    task automatic send_beats(input int tail, input int nb, input int sa, input int sb,
                              input bit clr);
        logic [DATA_W-1:0] d;
        for (int j = 0; j < nb; j++) begin
            if (j == sa || j == sb)
                repeat (3) begin
                    crc_en          = 1'b0;
                    crc_data_in     = DATA_W'({$urandom, $urandom});
                    frame_tail_flag = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            for (int i = 0; i < DATA_W; i++) d[i] = fb[j * DATA_W + DATA_W - 1 - i];
            crc_en          = 1'b1;
            crc_data_in     = d;
            frame_tail_flag = (j == tail);
            cnt_clr         = clr && (j == nb - 1);
            @(negedge clk);
        end
        crc_en          = 1'b0;
        frame_tail_flag = 1'b0;
        cnt_clr         = 1'b0;
    endtask

    task automatic run_frame(input int tail, input int nb, input int sa, input int sb,
                             input bit clr, output int lat);
        int st, n;
        st = cyc;
        send_beats(tail, nb, sa, sb, clr);
        n = 0;
        while (!check_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        lat = cyc - st;
    endtask

    task automatic check_frame(input string nm, input bit res, input logic [3:0] blk,
                               input bit ferr, input bit clr, input int exp_lat,
                               input int lat, input bit pulse);
        if (clr) begin
            m23 = 0;
            m3  = 0;
            for (int k = 0; k < NUM_BLK; k++) mb[k] = 0;
        end else begin
            if (!res) begin
                m23++;
                if (m3 < 7) m3++;
            end
            if (!ferr)
                for (int k = 0; k < NUM_BLK; k++) if (blk[k]) mb[k]++;
        end
        chk({nm, ".valid"}, 128'(check_valid), 128'(1));
        chk({nm, ".result"}, 128'(check_result), 128'(res));
        chk({nm, ".blk_err"}, 128'(blk_err), 128'(blk));
        chk({nm, ".frame_err"}, 128'(frame_err), 128'(ferr));
        chk({nm, ".cnt"}, 128'(error_packet_cnt), 128'(m23));
        chk({nm, ".valid3"}, 128'(cv3), 128'(1));
        chk({nm, ".result3"}, 128'(cr3), 128'(res));
        chk({nm, ".blk_err3"}, 128'(be3), 128'(blk));
        chk({nm, ".frame_err3"}, 128'(fe3), 128'(ferr));
        chk({nm, ".cnt3"}, 128'(cnt3), 128'(m3));
`ifdef CRC_CHK_BLK_CNT_EN
        chk({nm, ".blk_cnt"}, 128'(bcnt), exp_bcnt(CNT_W));
        chk({nm, ".blk_cnt3"}, 128'(bcnt3), exp_bcnt(3));
`endif
        if (exp_lat >= 0) chk({nm, ".latency"}, 128'(lat), 128'(exp_lat));
        if (pulse) begin
            @(negedge clk);
            chk({nm, ".pulse"}, 128'(check_valid), 128'(0));
        end
    endtask

    initial begin
        int         lat, s, tail, nb, sa, fl, mode, pos;
        bit         clr;
        logic [3:0] eb;

        s = 0;
        for (int k = 0; k < NUM_BLK; k++) begin
            blen[k] = int'(BLK_LEN[16*k +: 16]);
            bst[k]  = s;
            s += blen[k];
        end
        ltot = s;
        m23  = 0;
        m3   = 0;
        for (int k = 0; k < NUM_BLK; k++) mb[k] = 0;

        rst_n           = 1'b0;
        crc_en          = 1'b0;
        crc_data_in     = '0;
        frame_tail_flag = 1'b0;
        cnt_clr         = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.valid", 128'(check_valid), 128'(0));
        chk("rst.result", 128'(check_result), 128'(0));
        chk("rst.blk_err", 128'(blk_err), 128'(0));
        chk("rst.frame_err", 128'(frame_err), 128'(0));
        chk("rst.cnt", 128'(error_packet_cnt), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        vt[0] = '{"good",    -1, 25, 26, -1, -1, 1'b0, 1'b1, 4'b0000, 1'b0};
        vt[1] = '{"blk2",     2, 25, 26, -1, -1, 1'b0, 1'b0, 4'b0100, 1'b0};
        vt[2] = '{"early20", -1, 20, 21, -1, -1, 1'b0, 1'b0, 4'b1111, 1'b1};
        vt[3] = '{"good2",   -1, 25, 26, -1, -1, 1'b0, 1'b1, 4'b0000, 1'b0};
        vt[4] = '{"notail",  -1, -1, 26, -1, -1, 1'b0, 1'b0, 4'b1111, 1'b1};
        vt[5] = '{"single",  -1,  0,  1, -1, -1, 1'b0, 1'b0, 4'b1111, 1'b1};
        vt[6] = '{"stall",   -1, 25, 26,  5, 24, 1'b0, 1'b1, 4'b0000, 1'b0};
        vt[7] = '{"blk1a",    1, 25, 26, -1, -1, 1'b0, 1'b0, 4'b0010, 1'b0};
        vt[8] = '{"blk1b",    1, 25, 26, -1, -1, 1'b0, 1'b0, 4'b0010, 1'b0};
        vt[9] = '{"blk3",     3, 25, 26, -1, -1, 1'b0, 1'b0, 4'b1000, 1'b0};

        for (int v = 0; v < 10; v++) begin
            build_test(vt[v].flip);
            run_frame(vt[v].tail, vt[v].nb, vt[v].sa, vt[v].sb, vt[v].clr, lat);
            check_frame(vt[v].nm, vt[v].res, vt[v].blk, vt[v].ferr, vt[v].clr,
                        vt[v].nb + (vt[v].sa >= 0 ? 3 : 0) + (vt[v].sb >= 0 ? 3 : 0),
                        lat, 1'b1);
        end

        // Back-to-back frames with no idle beat between them.
        build_test(0);
        send_beats(25, 26, -1, -1, 1'b0);
        check_frame("b2b_a", 1'b0, 4'b0001, 1'b0, 1'b0, -1, 0, 1'b0);
        build_test(-1);
        run_frame(25, 26, -1, -1, 1'b0, lat);
        check_frame("b2b_b", 1'b1, 4'b0000, 1'b0, 1'b0, 26, lat, 1'b1);

        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        m23 = 0;
        m3  = 0;
        for (int k = 0; k < NUM_BLK; k++) mb[k] = 0;
        chk("clr.cnt", 128'(error_packet_cnt), 128'(0));
        chk("clr.cnt3", 128'(cnt3), 128'(0));
`ifdef CRC_CHK_BLK_CNT_EN
        chk("clr.blk_cnt", 128'(bcnt), 128'(0));
`endif

        for (int f = 0; f < 9; f++) begin
            fl = $urandom_range(0, NUM_BLK - 1);
            build_test(fl);
            eb = '0;
            eb[fl] = 1'b1;
            run_frame(25, 26, -1, -1, 1'b0, lat);
            check_frame("sat", 1'b0, eb, 1'b0, 1'b0, 26, lat, 1'b1);
        end
        chk("sat.cnt3_max", 128'(cnt3), 128'(7));
        chk("sat.cnt23", 128'(error_packet_cnt), 128'(9));
        build_test(2);
        run_frame(25, 26, -1, -1, 1'b1, lat);
        check_frame("sat_clr", 1'b0, 4'b0100, 1'b0, 1'b1, 26, lat, 1'b1);

        build_test(1);
        run_frame(25, 26, -1, -1, 1'b0, lat);
        check_frame("prerst", 1'b0, 4'b0010, 1'b0, 1'b0, 26, lat, 1'b1);
        build_test(-1);
        send_beats(-1, 10, -1, -1, 1'b0);
        chk("midrst.noend", 128'(check_valid), 128'(0));
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst.valid", 128'(check_valid), 128'(0));
        chk("midrst.cnt", 128'(error_packet_cnt), 128'(0));
        chk("midrst.blk_err", 128'(blk_err), 128'(0));
        rst_n = 1'b1;
        m23 = 0;
        m3  = 0;
        for (int k = 0; k < NUM_BLK; k++) mb[k] = 0;
        @(negedge clk);
        run_frame(25, 26, -1, -1, 1'b0, lat);
        check_frame("postrst", 1'b1, 4'b0000, 1'b0, 1'b0, 26, lat, 1'b1);

        for (int f = 0; f < 30; f++) begin
            for (int b = 0; b < FB; b++) fb[b] = 1'($urandom_range(0, 1));
            put_crcs();
            fl = $urandom_range(0, 3);
            if (fl == 1 || fl == 2) begin
                pos = $urandom_range(0, ltot + NUM_BLK * CRC_W - 1);
                fb[pos] = ~fb[pos];
            end else if (fl == 3) begin
                pos = $urandom_range(ltot + NUM_BLK * CRC_W, FB - 1);
                fb[pos] = ~fb[pos];
            end
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                tail = $urandom_range(0, BEATS - 2);
                nb   = tail + 1;
            end else if (mode == 1) begin
                tail = -1;
                nb   = BEATS;
            end else begin
                tail = BEATS - 1;
                nb   = BEATS;
            end
            sa  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb - 1) : -1;
            clr = ($urandom_range(0, 7) == 0);
            eb  = (tail == BEATS - 1) ? model_blk() : 4'b1111;
            run_frame(tail, nb, sa, -1, clr, lat);
            check_frame("rand", (tail == BEATS - 1) && (eb == 4'b0000), eb,
                        tail != BEATS - 1, clr, nb + (sa >= 0 ? 3 : 0), lat, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
